// File: rtl/hub75_pkg.sv
// hub75_pkg: state type, colour field indices and on-time helper shared by the
// HUB75 binary-coded-modulation driver and its plane selector.
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        CLK_HI,
        CLK_LO,
        LATCH,
        WAIT,
        NEXT
    } hub75_state_t;

    // Field positions inside a packed {R,G,B} pixel word and inside the 3-bit serial bus
    localparam int RED   = 2;
    localparam int GREEN = 1;
    localparam int BLUE  = 0;

    // Display time of one bit-plane: plane b is lit for base << b clocks
    function automatic int unsigned plane_ticks(input int unsigned base, input int unsigned plane);
        return base << plane;
    endfunction

endpackage

// File: rtl/hub75_plane_select.sv
// hub75_plane_select: picks one bit-plane out of a packed {R,G,B} pixel word.
// Each colour field is COLOR_BITS wide, MSB first; the result is {R,G,B}.
module hub75_plane_select
    import hub75_pkg::*;
#(
    parameter int COLOR_BITS = 2,
    parameter int PLANE_W    = 1
) (
    input  logic [3*COLOR_BITS-1:0] pixel,
    input  logic [PLANE_W-1:0]      plane,
    output logic [2:0]              rgb
);

    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;

    // Split the word into colour fields and take the selected bit of each
    always_comb begin
        red        = pixel[RED*COLOR_BITS   +: COLOR_BITS];
        green      = pixel[GREEN*COLOR_BITS +: COLOR_BITS];
        blue       = pixel[BLUE*COLOR_BITS  +: COLOR_BITS];
        rgb        = '0;
        rgb[RED]   = red[plane];
        rgb[GREEN] = green[plane];
        rgb[BLUE]  = blue[plane];
    end

endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: dual-scan HUB75 panel scanner with binary-coded modulation.
// Each row is shifted out with the panel dark, latched, then lit for
// BASE_TICKS << plane clocks. A done pulse marks the end of every frame.
// Optional macro HUB75_BRIGHTNESS_EN adds an 8-bit brightness input that
// shortens the lit part of each WAIT without changing its length.
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int ROW_W      = 4,
    parameter int COLOR_BITS = 2,
    parameter int BASE_TICKS = 32,
    parameter int ADDR_W     = ROW_W + $clog2(COLS),
    localparam int PLANE_W   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]              brightness,
`endif
    output logic [ADDR_W-1:0]       pixelAddress0,
    input  logic [3*COLOR_BITS-1:0] pixel0,
    output logic [ADDR_W-1:0]       pixelAddress1,
    input  logic [3*COLOR_BITS-1:0] pixel1,
    output logic [ROW_W-1:0]        rowDecoder,
    output logic                    pixelClk,
    output logic [2:0]              columnPixels0,
    output logic [2:0]              columnPixels1,
    output logic                    columnLatch,
    output logic                    blank,
    output logic                    done,
    output logic [PLANE_W-1:0]      plane
);

    localparam int COL_W   = $clog2(COLS);
    localparam int TIMER_W = $clog2(BASE_TICKS << (COLOR_BITS - 1)) + 1;
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(COLOR_BITS - 1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);

    hub75_state_t         state;
    hub75_state_t         next_state;
    logic [COL_W-1:0]     column;
    logic [ROW_W-1:0]     row;
    logic [ROW_W-1:0]     row_dec;
    logic [PLANE_W-1:0]   plane_q;
    logic [TIMER_W-1:0]   timer;
    logic [2:0]           bits0;
    logic [2:0]           bits1;
    logic [2:0]           rgb0;
    logic [2:0]           rgb1;
    logic [31:0]          plane_len;
    logic                 column_last;
    logic                 row_last;
    logic                 timer_last;
    logic                 frame_end;
`ifdef HUB75_BRIGHTNESS_EN
    logic [31:0]          on_limit;
    logic                 wait_dark;
`endif

    hub75_plane_select #(
        .COLOR_BITS (COLOR_BITS),
        .PLANE_W    (PLANE_W)
    ) u_select0 (
        .pixel (pixel0),
        .plane (plane_q),
        .rgb   (rgb0)
    );

    hub75_plane_select #(
        .COLOR_BITS (COLOR_BITS),
        .PLANE_W    (PLANE_W)
    ) u_select1 (
        .pixel (pixel1),
        .plane (plane_q),
        .rgb   (rgb1)
    );

    // Both halves read the same location; COLS is a power of two so row*COLS+column is a concat
    assign pixelAddress0 = ADDR_W'({row, column});
    assign pixelAddress1 = ADDR_W'({row, column});
    assign rowDecoder    = row_dec;
    assign columnPixels0 = bits0;
    assign columnPixels1 = bits1;
    assign plane         = plane_q;

    // Position flags and the current plane's on-time used by both the FSM and the datapath
    always_comb begin
        plane_len   = plane_ticks(BASE_TICKS, 32'(plane_q));
        column_last = (column == LAST_COL);
        row_last    = (row == '1);
        timer_last  = (32'(timer) == plane_len - 32'd1);
        frame_end   = row_last && (plane_q == LAST_PLANE);
`ifdef HUB75_BRIGHTNESS_EN
        on_limit    = (plane_len * 32'(brightness)) >> 8;
        wait_dark   = (32'(timer) >= on_limit);
`endif
    end

    // State register; reset drops straight to IDLE so the panel goes dark immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: shift four cycles per column, latch, display, advance row/plane
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = enable ? FETCH : IDLE;
            FETCH:   next_state = CAPTURE;
            CAPTURE: next_state = CLK_HI;
            CLK_HI:  next_state = CLK_LO;
            CLK_LO:  next_state = column_last ? LATCH : FETCH;
            LATCH:   next_state = WAIT;
            WAIT:    next_state = timer_last ? NEXT : WAIT;
            NEXT:    next_state = (frame_end && !enable) ? IDLE : FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; the panel is dark everywhere except while a row is being displayed
    always_comb begin
        pixelClk    = 1'b0;
        columnLatch = 1'b0;
        blank       = 1'b1;
        done        = 1'b0;
        case (state)
            CLK_HI:  pixelClk = 1'b1;
            LATCH:   columnLatch = 1'b1;
`ifdef HUB75_BRIGHTNESS_EN
            WAIT:    blank = wait_dark;
`else
            WAIT:    blank = 1'b0;
`endif
            NEXT:    done = frame_end;
            default: ;
        endcase
    end

    // Scan counters, display timer and registered serial data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            column  <= '0;
            row     <= '0;
            row_dec <= '0;
            plane_q <= '0;
            timer   <= '0;
            bits0   <= '0;
            bits1   <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    bits0 <= rgb0;
                    bits1 <= rgb1;
                end
                CLK_LO: begin
                    column <= column + 1'b1;
                    if (column_last) begin
                        row_dec <= row;
                    end
                end
                LATCH: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (!timer_last) begin
                        timer <= timer + 1'b1;
                    end
                end
                NEXT: begin
                    row <= row + 1'b1;
                    if (row_last) begin
                        plane_q <= (plane_q == LAST_PLANE) ? '0 : plane_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: directed/randomised bench for hub75_bcm_driver.
// A default-size instance is driven from a random RAM model and checked row by
// row against on-times and shift data derived from the panel rules; a small
// 3-bit-plane instance checks the WAIT length sequence across a whole frame.
module tb_hub75_bcm_driver;

    localparam int COLS       = 32;
    localparam int ROW_W      = 4;
    localparam int COLOR_BITS = 2;
    localparam int BASE_TICKS = 32;
    localparam int ADDR_W     = ROW_W + $clog2(COLS);
    localparam int ROWS       = 1 << ROW_W;
    localparam int PLANE_W    = 1;

    localparam int S_COLS   = 8;
    localparam int S_ROW_W  = 1;
    localparam int S_BITS   = 3;
    localparam int S_BASE   = 4;
    localparam int S_ADDR_W = S_ROW_W + $clog2(S_COLS);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [ADDR_W-1:0]       pixel_address0;
    logic [ADDR_W-1:0]       pixel_address1;
    logic [3*COLOR_BITS-1:0] pixel0;
    logic [3*COLOR_BITS-1:0] pixel1;
    logic [ROW_W-1:0]        row_decoder;
    logic                    pixel_clk;
    logic [2:0]              column_pixels0;
    logic [2:0]              column_pixels1;
    logic                    column_latch;
    logic                    blank;
    logic                    done;
    logic [PLANE_W-1:0]      plane;

    logic                    enable_s;
    logic [S_ADDR_W-1:0]     address_s0;
    logic [S_ADDR_W-1:0]     address_s1;
    logic [3*S_BITS-1:0]     pixel_s0;
    logic [3*S_BITS-1:0]     pixel_s1;
    logic [S_ROW_W-1:0]      row_s;
    logic                    pixel_clk_s;
    logic [2:0]              column_s0;
    logic [2:0]              column_s1;
    logic                    latch_s;
    logic                    blank_s;
    logic                    done_s;
    logic [1:0]              plane_s;

`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]              brightness = 8'd128;
`endif

    logic [3*COLOR_BITS-1:0] ram0 [0:(1<<ADDR_W)-1];
    logic [3*COLOR_BITS-1:0] ram1 [0:(1<<ADDR_W)-1];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    hub75_bcm_driver #(
        .COLS (COLS), .ROW_W (ROW_W), .COLOR_BITS (COLOR_BITS), .BASE_TICKS (BASE_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness    (brightness),
`endif
        .pixelAddress0 (pixel_address0),
        .pixel0        (pixel0),
        .pixelAddress1 (pixel_address1),
        .pixel1        (pixel1),
        .rowDecoder    (row_decoder),
        .pixelClk      (pixel_clk),
        .columnPixels0 (column_pixels0),
        .columnPixels1 (column_pixels1),
        .columnLatch   (column_latch),
        .blank         (blank),
        .done          (done),
        .plane         (plane)
    );

    hub75_bcm_driver #(
        .COLS (S_COLS), .ROW_W (S_ROW_W), .COLOR_BITS (S_BITS), .BASE_TICKS (S_BASE)
    ) dut_small (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable_s),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness    (brightness),
`endif
        .pixelAddress0 (address_s0),
        .pixel0        (pixel_s0),
        .pixelAddress1 (address_s1),
        .pixel1        (pixel_s1),
        .rowDecoder    (row_s),
        .pixelClk      (pixel_clk_s),
        .columnPixels0 (column_s0),
        .columnPixels1 (column_s1),
        .columnLatch   (latch_s),
        .blank         (blank_s),
        .done          (done_s),
        .plane         (plane_s)
    );

    // Synchronous pixel RAM: data follows the address by one clock
    always @(posedge clk) begin
        pixel0 <= ram0[pixel_address0];
        pixel1 <= ram1[pixel_address1];
    end

    // Lit clocks within a WAIT of the given length
    function automatic int onTicks(input int ticks);
`ifdef HUB75_BRIGHTNESS_EN
        return (ticks * int'(brightness)) >> 8;
`else
        return ticks;
`endif
    endfunction

    // Bit pl of R, G and B of a packed pixel, as {R,G,B}
    function automatic logic [2:0] planeBits(input logic [3*COLOR_BITS-1:0] word, input int pl);
        return {word[2*COLOR_BITS + pl], word[COLOR_BITS + pl], word[pl]};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en);
        @(negedge clk);
        enable = en;
    endtask

    // Walk one row (shift, latch, display, next) starting at its first FETCH cycle
    task automatic checkRow(input int row, input int pl, output logic [3*COLS-1:0] obs0);
        int ticks, len, clk_n, first_clk, latch_n, latch_idx, on_n, first_on, done_n, exp_done;
        logic [3*COLS-1:0] exp0, exp1, obs1;
        logic [ROW_W-1:0] dec_at_latch;
        logic [PLANE_W-1:0] plane_at_latch;
        logic done_last;
        string t;
        ticks = BASE_TICKS << pl;
        len = 4*COLS + 1 + ticks + 1;
        clk_n = 0; first_clk = -1; latch_n = 0; latch_idx = -1;
        on_n = 0; first_on = -1; done_n = 0; done_last = 1'b0;
        dec_at_latch = '0; plane_at_latch = '0;
        obs0 = '0; obs1 = '0;
        for (int c = 0; c < COLS; c++) begin
            exp0[3*c +: 3] = planeBits(ram0[row*COLS + c], pl);
            exp1[3*c +: 3] = planeBits(ram1[row*COLS + c], pl);
        end
        exp_done = (row == ROWS-1 && pl == COLOR_BITS-1) ? 1 : 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (pixel_clk) begin
                if (clk_n == 0) first_clk = i;
                if (clk_n < COLS) begin
                    obs0[3*clk_n +: 3] = column_pixels0;
                    obs1[3*clk_n +: 3] = column_pixels1;
                end
                clk_n++;
            end
            if (column_latch) begin
                if (latch_n == 0) begin
                    latch_idx = i;
                    dec_at_latch = row_decoder;
                    plane_at_latch = plane;
                end
                latch_n++;
            end
            if (!blank) begin
                if (first_on < 0) first_on = i;
                on_n++;
            end
            if (done) done_n++;
            done_last = done;
        end
        t = $sformatf("r%0d_p%0d", row, pl);
        checkOutput({t, "_clks"},     128'(clk_n),     128'(COLS));
        checkOutput({t, "_firstclk"}, 128'(first_clk), 128'(2));
        checkOutput({t, "_data0"},    128'(obs0),      128'(exp0));
        checkOutput({t, "_data1"},    128'(obs1),      128'(exp1));
        checkOutput({t, "_latches"},  128'(latch_n),   128'(1));
        checkOutput({t, "_latchidx"}, 128'(latch_idx), 128'(4*COLS));
        checkOutput({t, "_rowdec"},   128'(dec_at_latch),   128'(row));
        checkOutput({t, "_plane"},    128'(plane_at_latch), 128'(pl));
        checkOutput({t, "_ontime"},   128'(on_n),      128'(onTicks(ticks)));
        checkOutput({t, "_firston"},  128'(first_on),  128'((onTicks(ticks) > 0) ? 4*COLS + 1 : -1));
        checkOutput({t, "_donecnt"},  128'(done_n),    128'(exp_done));
        checkOutput({t, "_donelast"}, 128'(done_last), 128'(exp_done));
    endtask

    // One full frame: every row of every plane, optionally dropping enable at a row of plane 0
    task automatic runFrame(input int drop_row, input logic pattern);
        logic [3*COLS-1:0] obs;
        for (int pl = 0; pl < COLOR_BITS; pl++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (pl == 0 && r == drop_row) enable = 1'b0;
                checkRow(r, pl, obs);
                if (pattern && r == 0) begin
                    checkOutput($sformatf("pattern_p%0d", pl), 128'(obs),
                                (pl == 0) ? 128'({COLS{3'b011}}) : 128'({COLS{3'b101}}));
                end
            end
        end
    endtask

    // Small 3-plane instance: WAIT lengths, single done, return to idle
    task automatic smallFrame();
        int runs[$];
        int run, n_done, runs_at_done, clk_after;
        logic seen_done;
        run = 0; n_done = 0; runs_at_done = -1; clk_after = 0; seen_done = 1'b0;
        pixel_s0 = 9'($urandom);
        pixel_s1 = 9'($urandom);
        @(negedge clk);
        enable_s = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (i == 1) enable_s = 1'b0;
            if (!blank_s) run++;
            else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (seen_done && pixel_clk_s) clk_after++;
            if (done_s) begin
                n_done++;
                runs_at_done = runs.size();
                seen_done = 1'b1;
            end
        end
        checkOutput("small_nwaits", 128'(runs.size()), 128'(6));
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("small_wait%0d", k),
                        128'((k < runs.size()) ? runs[k] : -1), 128'(onTicks(S_BASE << (k/2))));
        end
        checkOutput("small_done_cnt",  128'(n_done),       128'(1));
        checkOutput("small_done_pos",  128'(runs_at_done), 128'(6));
        checkOutput("small_clk_after", 128'(clk_after),    128'(0));
        checkOutput("small_plane_end", 128'(plane_s),      128'(0));
        checkOutput("small_blank_end", 128'(blank_s),      128'(1));
    endtask

    initial begin
        int n_clk, n_done, n_lit;
        logic found;
        rst = 1'b0;
        enable = 1'b0;
        enable_s = 1'b0;
        pixel_s0 = '0;
        pixel_s1 = '0;
        for (int a = 0; a < (1<<ADDR_W); a++) begin
            ram0[a] = 6'b10_01_11;
            ram1[a] = 6'($urandom);
        end

        $display("[TB] reset values");
        repeat (3) @(negedge clk);
        checkOutput("rst_blank",   128'(blank),          128'(1));
        checkOutput("rst_pclk",    128'(pixel_clk),      128'(0));
        checkOutput("rst_latch",   128'(column_latch),   128'(0));
        checkOutput("rst_done",    128'(done),           128'(0));
        checkOutput("rst_rowdec",  128'(row_decoder),    128'(0));
        checkOutput("rst_plane",   128'(plane),          128'(0));
        checkOutput("rst_addr0",   128'(pixel_address0), 128'(0));
        checkOutput("rst_addr1",   128'(pixel_address1), 128'(0));
        checkOutput("rst_cp0",     128'(column_pixels0), 128'(0));
        checkOutput("rst_cp1",     128'(column_pixels1), 128'(0));
        checkOutput("rst_s_blank", 128'(blank_s),        128'(1));
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] constant-pattern frame");
        applyStimulus(1'b1);
        runFrame(-1, 1'b1);

        $display("[TB] random frame, enable dropped at row 5");
        for (int a = 0; a < (1<<ADDR_W); a++) begin
            ram0[a] = 6'($urandom);
            ram1[a] = 6'($urandom);
        end
        runFrame(5, 1'b0);
        n_clk = 0; n_done = 0; n_lit = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pixel_clk) n_clk++;
            if (done) n_done++;
            if (!blank) n_lit++;
        end
        checkOutput("idle_pclk", 128'(n_clk),  128'(0));
        checkOutput("idle_done", 128'(n_done), 128'(0));
        checkOutput("idle_lit",  128'(n_lit),  128'(0));

        $display("[TB] asynchronous reset during CLK_HI");
        applyStimulus(1'b1);
        for (int r = 0; r < 3; r++) begin
            logic [3*COLS-1:0] obs;
            checkRow(r, 0, obs);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pixel_clk) found = 1'b1;
        end
        checkOutput("ar_found_clkhi", 128'(found), 128'(1));
        enable = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("ar_pclk",  128'(pixel_clk),    128'(0));
        checkOutput("ar_blank", 128'(blank),        128'(1));
        checkOutput("ar_done",  128'(done),         128'(0));
        checkOutput("ar_latch", 128'(column_latch), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ar_rowdec", 128'(row_decoder),    128'(0));
        checkOutput("ar_plane",  128'(plane),          128'(0));
        checkOutput("ar_addr",   128'(pixel_address0), 128'(0));
        checkOutput("ar_idle",   128'(blank),          128'(1));

        $display("[TB] small instance: 3 planes, base 4");
        smallFrame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
